// File: rtl/cache_fill_pkg.sv
// Shared types and helpers for the cache miss-fill controller: state encoding,
// default block geometry, and block-base address alignment.
package cache_fill_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int DEF_WORDS_PER_BLOCK = 8;
    localparam int OFFSET_BITS         = $clog2(DEF_WORDS_PER_BLOCK) + 1;
    localparam int CNT_W               = $clog2(DEF_WORDS_PER_BLOCK) + 1;

    // Clears the byte-offset bits so the result points at the first byte of the block.
    function automatic logic [63:0] block_base(input logic [63:0] addr,
                                               input int unsigned offset_bits = OFFSET_BITS);
        return addr & ~((64'd1 << offset_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/cache_fill_cnt.sv
// Clearable up-counter with a terminal-count flag; one instance tracks issued
// requests, another tracks returned words. Clear has priority over enable.
module cache_fill_cnt
    import cache_fill_pkg::*;
#(
    parameter int          W        = CNT_W,
    parameter int unsigned TERMINAL = DEF_WORDS_PER_BLOCK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == W'(TERMINAL));

endmodule

// File: rtl/cache_fill_fsm.sv
// L1 miss controller: issues one word read per cycle for the whole block, steers returns into the
// data array, pulses the tag write on the last word; never stalls requests. CACHE_FILL_PERF_CNT_EN adds perf counters.
module cache_fill_fsm
    import cache_fill_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic [ADDR_WIDTH-1:0] fill_address,
    output logic                  write_tag_array
`ifdef CACHE_FILL_PERF_CNT_EN
    ,
    output logic [15:0]           fill_count,
    output logic [15:0]           stall_cycles
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK) + 1;
    localparam int CW    = $clog2(WORDS_PER_BLOCK) + 1;

    // The controller itself is latency-agnostic; the range only bounds how far returns may trail requests.
    if (MEM_LATENCY < 1 || MEM_LATENCY > 8 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_param_check
        $error("cache_fill_fsm: MEM_LATENCY must be 1..8 and WORDS_PER_BLOCK a power of two");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;

    logic          cnt_clr;
    logic          req_en;
    logic          rsp_en;
    logic [CW-1:0] req_cnt;
    logic [CW-1:0] rsp_cnt;
    logic          req_done;
    logic          rsp_last;

    logic [ADDR_WIDTH-1:0] req_off;
    logic [ADDR_WIDTH-1:0] rsp_off;

    cache_fill_cnt #(
        .W        (CW),
        .TERMINAL (WORDS_PER_BLOCK)
    ) u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (req_en),
        .cnt_o (req_cnt),
        .tc_o  (req_done)
    );

    cache_fill_cnt #(
        .W        (CW),
        .TERMINAL (WORDS_PER_BLOCK - 1)
    ) u_rsp_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (rsp_en),
        .cnt_o (rsp_cnt),
        .tc_o  (rsp_last)
    );

    // Once all requests are out, the address parks on the last word instead of spilling into the next block.
    assign req_off = req_done ? ADDR_WIDTH'(2 * (WORDS_PER_BLOCK - 1)) : ADDR_WIDTH'({req_cnt, 1'b0});
    assign rsp_off = ADDR_WIDTH'({rsp_cnt, 1'b0});

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        cnt_clr          = 1'b0;
        req_en           = 1'b0;
        rsp_en           = 1'b0;
        fsm_busy         = 1'b0;
        mem_enable       = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_address     = '0;
        write_tag_array  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (miss_detected) begin
                    state_d = FILL;
                    base_d  = ADDR_WIDTH'(block_base(64'(miss_address), OFF_W));
                end
            end
            FILL: begin
                fsm_busy       = 1'b1;
                mem_enable     = !req_done;
                req_en         = !req_done;
                memory_address = base_q + req_off;
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_address     = base_q + rsp_off;
                    rsp_en           = 1'b1;
                    if (rsp_last) begin
                        write_tag_array = 1'b1;
                        cnt_clr         = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

`ifdef CACHE_FILL_PERF_CNT_EN
    logic [15:0] fill_count_q;
    logic [15:0] stall_cycles_q;

    // Aborted fills never reach the tag pulse, so only completed fills are counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_count_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (write_tag_array && fill_count_q != 16'hFFFF) begin
                fill_count_q <= fill_count_q + 16'd1;
            end
            if (fsm_busy && stall_cycles_q != 16'hFFFF) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
        end
    end

    assign fill_count   = fill_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a latency-programmable memory model answers requests,
// and each scenario compares observed request/write/tag streams against block arithmetic.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_enable;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_address;
    logic        write_tag_array;
`ifdef CACHE_FILL_PERF_CNT_EN
    logic [15:0] fill_count;
    logic [15:0] stall_cycles;
`endif

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_enable        (mem_enable),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_address      (fill_address),
        .write_tag_array   (write_tag_array)
`ifdef CACHE_FILL_PERF_CNT_EN
        ,
        .fill_count        (fill_count),
        .stall_cycles      (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // memory model and observation logs
    int          cyc = 0;
    int          lat = 4;
    bit          resp_due[int];
    logic [15:0] req_q[$];
    logic [15:0] wr_q[$];
    int          tag_cnt;
    int          tag_cyc;
    int          busy_cnt;
    int          busy_first;
    int          bad_wr;
    logic        s_busy, s_men, s_wde, s_tag;
    logic [15:0] s_maddr, s_faddr;

    task automatic clear_logs();
        req_q.delete();
        wr_q.delete();
        tag_cnt    = 0;
        tag_cyc    = -1;
        busy_cnt   = 0;
        busy_first = -1;
        bad_wr     = 0;
    endtask

    // One clock cycle: drive at negedge, observe 1ns later, then let the rising edge happen.
    task automatic step(input bit r, input bit miss, input logic [15:0] addr, input bit vforce);
        @(negedge clk);
        rst               = r;
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = vforce || resp_due.exists(cyc);
        if (resp_due.exists(cyc)) resp_due.delete(cyc);
        #1;
        if (mem_enable) begin
            req_q.push_back(memory_address);
            resp_due[cyc + lat] = 1'b1;
        end
        if (write_data_array) wr_q.push_back(fill_address);
        if (write_data_array && !memory_data_valid) bad_wr++;
        if (write_tag_array) begin
            tag_cnt++;
            tag_cyc = cyc;
        end
        if (fsm_busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cyc;
        end
        s_busy  = fsm_busy;
        s_men   = mem_enable;
        s_maddr = memory_address;
        s_wde   = write_data_array;
        s_faddr = fill_address;
        s_tag   = write_tag_array;
        @(posedge clk);
        cyc++;
    endtask

    task automatic run_fill(input logic [15:0] addr, input bit spur);
        bit done = 1'b0;
        step(1'b0, 1'b1, addr, 1'b0);
        for (int i = 0; i < 40 && !done; i++) begin
            step(1'b0, spur && (i == 3), 16'h5550, 1'b0);
            if (!s_busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL fill_timeout addr=%h busy=%0b required=0", addr, s_busy);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        checks += 6;
        if (s_busy  !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
        if (s_men   !== 1'b0)  begin errors++; $display("FAIL reset_men got=%b exp=0", s_men); end
        if (s_maddr !== 16'h0) begin errors++; $display("FAIL reset_maddr got=%h exp=0000", s_maddr); end
        if (s_wde   !== 1'b0)  begin errors++; $display("FAIL reset_wde got=%b exp=0", s_wde); end
        if (s_faddr !== 16'h0) begin errors++; $display("FAIL reset_faddr got=%h exp=0000", s_faddr); end
        if (s_tag   !== 1'b0)  begin errors++; $display("FAIL reset_tag got=%b exp=0", s_tag); end
        step(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_basic_fill();
        logic [15:0] base, got, exp;
        lat = 4;
        clear_logs();
        run_fill(16'h1234, 1'b0);
        base = 16'h1230;
        checks += 5;
        if (req_q.size() != 8) begin errors++; $display("FAIL basic_nreq got=%0d exp=8", req_q.size()); end
        if (wr_q.size() != 8)  begin errors++; $display("FAIL basic_nwr got=%0d exp=8", wr_q.size()); end
        if (tag_cnt != 1)      begin errors++; $display("FAIL basic_tag got=%0d exp=1", tag_cnt); end
        if (busy_cnt != 12)    begin errors++; $display("FAIL basic_busy got=%0d exp=12", busy_cnt); end
        if (bad_wr != 0)       begin errors++; $display("FAIL basic_wr_no_valid got=%0d exp=0", bad_wr); end
        for (int i = 0; i < 8; i++) begin
            exp = 16'(base + 16'(2 * i));
            got = (i < req_q.size()) ? req_q[i] : 16'hxxxx;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_req[%0d] got=%h exp=%h", i, got, exp); end
            got = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_wr[%0d] got=%h exp=%h", i, got, exp); end
        end
        checks++;
        if (tag_cyc - busy_first != 11) begin
            errors++;
            $display("FAIL basic_tag_cycle got=%0d exp=11", tag_cyc - busy_first);
        end
    endtask

    task automatic test_top_of_memory();
        logic [15:0] got, exp;
        int zero_hits = 0;
        lat = 4;
        clear_logs();
        run_fill(16'hFFFB, 1'b0);
        for (int i = 0; i < req_q.size(); i++) if (req_q[i] == 16'h0000) zero_hits++;
        checks += 2;
        if (req_q.size() != 8) begin errors++; $display("FAIL top_nreq got=%0d exp=8", req_q.size()); end
        if (zero_hits != 0)    begin errors++; $display("FAIL top_wrap got=%0d exp=0", zero_hits); end
        for (int i = 0; i < 8; i++) begin
            exp = 16'(16'hFFF0 + 16'(2 * i));
            got = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL top_wr[%0d] got=%h exp=%h", i, got, exp); end
        end
        checks++;
        if (req_q.size() > 7 && req_q[7] !== 16'hFFFE) begin
            errors++;
            $display("FAIL top_last_req got=%h exp=fffe", req_q[7]);
        end
    endtask

    task automatic test_spurious();
        logic [15:0] got;
        lat = 4;
        clear_logs();
        run_fill(16'h3006, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        checks += 4;
        if (tag_cnt != 1)      begin errors++; $display("FAIL spur_tag got=%0d exp=1", tag_cnt); end
        if (req_q.size() != 8) begin errors++; $display("FAIL spur_nreq got=%0d exp=8", req_q.size()); end
        if (wr_q.size() != 8)  begin errors++; $display("FAIL spur_nwr got=%0d exp=8", wr_q.size()); end
        if (busy_cnt != 12)    begin errors++; $display("FAIL spur_busy got=%0d exp=12", busy_cnt); end
        clear_logs();
        run_fill(16'h0F0E, 1'b0);
        got = (wr_q.size() > 0) ? wr_q[0] : 16'hxxxx;
        checks += 2;
        if (got !== 16'h0F00) begin errors++; $display("FAIL spur_next_wr0 got=%h exp=0f00", got); end
        got = (req_q.size() > 0) ? req_q[0] : 16'hxxxx;
        if (got !== 16'h0F00) begin errors++; $display("FAIL spur_next_req0 got=%h exp=0f00", got); end
    endtask

    task automatic test_reset_midfill();
        logic [15:0] got, exp;
        lat = 4;
        clear_logs();
        step(1'b0, 1'b1, 16'h2468, 1'b0);
        for (int i = 0; i < 20 && req_q.size() < 5; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        checks++;
        if (req_q.size() != 5) begin errors++; $display("FAIL mid_reach5 got=%0d exp=5", req_q.size()); end
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        clear_logs();
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        checks += 4;
        if (s_busy !== 1'b0 || s_men !== 1'b0 || s_tag !== 1'b0) begin
            errors++;
            $display("FAIL mid_ctrl busy=%b men=%b tag=%b exp=000", s_busy, s_men, s_tag);
        end
        if (s_maddr !== 16'h0) begin errors++; $display("FAIL mid_maddr got=%h exp=0000", s_maddr); end
        if (s_wde !== 1'b0)    begin errors++; $display("FAIL mid_wde got=%b exp=0", s_wde); end
        if (s_faddr !== 16'h0) begin errors++; $display("FAIL mid_faddr got=%h exp=0000", s_faddr); end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        checks += 2;
        if (wr_q.size() != 0) begin errors++; $display("FAIL mid_late_wr got=%0d exp=0", wr_q.size()); end
        if (tag_cnt != 0)     begin errors++; $display("FAIL mid_late_tag got=%0d exp=0", tag_cnt); end
        clear_logs();
        run_fill(16'h0040, 1'b0);
        checks += 2;
        if (tag_cnt != 1)   begin errors++; $display("FAIL mid_next_tag got=%0d exp=1", tag_cnt); end
        if (busy_cnt != 12) begin errors++; $display("FAIL mid_next_busy got=%0d exp=12", busy_cnt); end
        for (int i = 0; i < 8; i++) begin
            exp = 16'(16'h0040 + 16'(2 * i));
            got = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
            checks++;
            if (got !== exp) begin errors++; $display("FAIL mid_next_wr[%0d] got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_latency_sweep();
        int lats[2] = '{1, 8};
        foreach (lats[k]) begin
            lat = lats[k];
            clear_logs();
            run_fill(16'h0A5C, 1'b0);
            checks += 3;
            if (busy_cnt != 8 + lat) begin
                errors++; $display("FAIL lat%0d_busy got=%0d exp=%0d", lat, busy_cnt, 8 + lat);
            end
            if (tag_cyc - busy_first != 7 + lat) begin
                errors++; $display("FAIL lat%0d_done got=%0d exp=%0d", lat, tag_cyc - busy_first, 7 + lat);
            end
            if (wr_q.size() != 8) begin
                errors++; $display("FAIL lat%0d_nwr got=%0d exp=8", lat, wr_q.size());
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] addr, base, got, exp;
        for (int n = 0; n < 4; n++) begin
            addr = 16'($urandom);
            lat  = int'($urandom_range(8, 1));
            base = addr - (addr % 16'd16);
            clear_logs();
            run_fill(addr, 1'b0);
            checks += 2;
            if (tag_cnt != 1) begin errors++; $display("FAIL rnd%0d_tag got=%0d exp=1", n, tag_cnt); end
            if (busy_cnt != 8 + lat) begin
                errors++; $display("FAIL rnd%0d_busy got=%0d exp=%0d", n, busy_cnt, 8 + lat);
            end
            for (int i = 0; i < 8; i++) begin
                exp = 16'(base + 16'(2 * i));
                got = (i < req_q.size()) ? req_q[i] : 16'hxxxx;
                checks++;
                if (got !== exp) begin errors++; $display("FAIL rnd%0d_req[%0d] got=%h exp=%h", n, i, got, exp); end
                got = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
                checks++;
                if (got !== exp) begin errors++; $display("FAIL rnd%0d_wr[%0d] got=%h exp=%h", n, i, got, exp); end
            end
        end
    endtask

    task automatic test_back_to_back();
        lat = 4;
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        clear_logs();
        for (int i = 0; i < 80 && tag_cnt < 3; i++) step(1'b0, 1'b1, 16'(16'h0100 + 16'(16 * i)), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, 1'b0);
        checks += 3;
        if (tag_cnt != 3)       begin errors++; $display("FAIL b2b_tag got=%0d exp=3", tag_cnt); end
        if (busy_cnt != 36)     begin errors++; $display("FAIL b2b_busy got=%0d exp=36", busy_cnt); end
        if (req_q.size() != 24) begin errors++; $display("FAIL b2b_nreq got=%0d exp=24", req_q.size()); end
`ifdef CACHE_FILL_PERF_CNT_EN
        @(negedge clk);
        checks += 2;
        if (fill_count !== 16'd3)    begin errors++; $display("FAIL perf_fill got=%0d exp=3", fill_count); end
        if (stall_cycles !== 16'd36) begin errors++; $display("FAIL perf_stall got=%0d exp=36", stall_cycles); end
`endif
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        clear_logs();
        test_reset();
        test_basic_fill();
        test_top_of_memory();
        test_spurious();
        test_reset_midfill();
        test_latency_sweep();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the L1 cache arrays and the multi-cycle backing memory (memory4c-style: 16-bit word, byte-addressed, fixed read latency).
- On a cache miss it fetches the whole 16-byte block (8 words) with pipelined reads, one request per cycle.
- Each returned word is steered into the data array. The tag array is updated when the last word lands.
- The core stalls on fsm_busy.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- MEM_LATENCY, 4, cycles from a request (mem_enable high at edge N) to memory_data_valid high at edge N+MEM_LATENCY; valid range 1..8.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- miss_detected, input, 1, cache lookup missed this cycle; sampled only in IDLE.
- miss_address, input, ADDR_WIDTH, byte address of the missing access.
- memory_data_valid, input, 1, backing memory returns one word this cycle.
- fsm_busy, output, 1, fill in progress; core stalls.
- mem_enable, output, 1, read request to backing memory (write enable is tied 0 outside this block).
- memory_address, output, ADDR_WIDTH, request byte address, always even.
- write_data_array, output, 1, write the returned word into the data array this cycle.
- fill_address, output, ADDR_WIDTH, byte address of the word being written into the data array.
- write_tag_array, output, 1, one-cycle pulse: write tag and set valid for the block.

Behaviour:
- Reset: state IDLE; req_cnt=0, rsp_cnt=0; all outputs 0 (fsm_busy, mem_enable, write_data_array, write_tag_array, memory_address, fill_address).
- States: IDLE, FILL.
- IDLE -> FILL when miss_detected=1 at an edge. Latch base = miss_address with the low log2(WORDS_PER_BLOCK)+1 bits cleared (0x1234 -> 0x1230). fsm_busy goes high the cycle after the miss.
- FILL request side:
  - while req_cnt < WORDS_PER_BLOCK: mem_enable=1, memory_address = base + 2*req_cnt, req_cnt increments each cycle.
  - afterwards mem_enable=0 and memory_address holds the last value.
  - Requests are never stalled.
- FILL response side:
  - when memory_data_valid=1: write_data_array=1 (combinational from valid in FILL), fill_address = base + 2*rsp_cnt, rsp_cnt increments.
- Completion: in the cycle where memory_data_valid=1 and rsp_cnt = WORDS_PER_BLOCK-1, write_tag_array=1. Next edge: state IDLE, counters cleared, fsm_busy=0.
- Total fill time: WORDS_PER_BLOCK + MEM_LATENCY cycles (12 with defaults).
- miss_detected while in FILL: ignored; no queueing.
- memory_data_valid while in IDLE: ignored; no array writes.
- Address arithmetic is modulo 2^ADDR_WIDTH. Block 0xFFF0 requests 0xFFF0..0xFFFE with no overflow into 0x0000.
- Reset mid-fill: immediate return to IDLE and outputs 0. Late responses arriving afterwards are dropped (IDLE rule).
- A miss coincident with the completion edge: not accepted (state is FILL at that edge); the cache re-asserts it next cycle.

Optional Feature:
- Macro CACHE_FILL_PERF_CNT_EN.
- When defined:
  - adds outputs fill_count[15:0] (completed fills) and stall_cycles[15:0] (cycles with fsm_busy=1).
  - both saturate at 0xFFFF and clear on rst.
  - an aborted (reset) fill is not counted.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package cache_fill_pkg holds:
  - state enum {IDLE, FILL};
  - localparams OFFSET_BITS = log2(WORDS_PER_BLOCK)+1 and CNT_W = log2(WORDS_PER_BLOCK)+1;
  - helper function block_base(addr).
- One natural sub-module, cache_fill_cnt: CNT_W-bit counter with clear/enable and a terminal-count flag. Instantiated twice (request, response).

Test Plan:
- Basic fill: rst, then miss_detected=1 with miss_address=0x1234 -> mem_enable high 8 cycles with addresses 0x1230..0x123E.
  - A latency-4 model returns 8 words.
  - write_data_array with fill_address 0x1230..0x123E.
  - write_tag_array pulses once.
  - fsm_busy low after 12 cycles.
- Top-of-memory block: miss_address=0xFFFB -> requests 0xFFF0..0xFFFE; no address 0x0000 issued.
- Spurious events: miss_detected pulsed in FILL, and memory_data_valid pulsed in IDLE -> no second fill, no array writes, counters unchanged.
- Reset mid-fill: rst asserted after 5 requests -> next cycle all outputs 0. Remaining 3 late valids cause no writes; a following miss at 0x0040 completes normally.
- Latency sweep: MEM_LATENCY=1 and 8 -> completion at exactly 9 and 16 cycles after fsm_busy rises.
- With CACHE_FILL_PERF_CNT_EN: 3 back-to-back fills -> fill_count=3, stall_cycles=36.
